// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage registers.
// Provides the stage occupancy state encoding and the occupancy width.
// Each state's encoding equals the number of entries it holds,
// so a state value can be used directly as an occupancy count.
package pipe_pkg;

  localparam int unsigned OccW = 2;

  typedef enum logic [OccW-1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } stage_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a per-cycle increment of 0..2.
// Ports:
//   clk_i  - clock
//   rst_i  - asynchronous active-low reset, clears the count
//   inc_i  - amount to add this cycle (0..2)
//   cnt_o  - registered count, sticks at all-ones instead of wrapping
module sat_counter
  import pipe_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [OccW-1:0]  inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   sum;

  always_comb begin
    sum = {1'b0, cnt_q} + (CNT_W+1)'(inc_i);
    // cnt_q <= max and inc_i <= 2, so a set carry bit means the sum passed max.
    if (sum[CNT_W]) begin
      cnt_d = '1;
    end else begin
      cnt_d = sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with a valid/ready handshake and a two-entry skid buffer.
// in_ready_o is derived only from registered state and stall_i, so there is no
// combinational path from out_ready_i back to upstream.
// Ports:
//   clk_i, rst_i              - clock, asynchronous active-low reset
//   in_valid_i/in_ready_o     - upstream handshake, in_data_i payload
//   out_valid_o/out_ready_i   - downstream handshake, out_data_o registered payload
//   stall_i                   - freeze: no enqueue, no dequeue
//   flush_i                   - discard all entries (wins over stall and transfers)
//   occupancy_o               - number of held entries (0..2)
//   drop_cnt_o                - saturating count of valid entries discarded by flush
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int unsigned          DATA_W     = 64,
  parameter logic [DATA_W-1:0]    BUBBLE_VAL = '0,
  parameter int unsigned          CNT_W      = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic [OccW-1:0]   occupancy_o,
  output logic [CNT_W-1:0]  drop_cnt_o
);

  stage_state_e      state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_fire, out_fire;
  logic [OccW-1:0]   drop_inc;

  assign in_ready_o  = (state_q != StFull) && !stall_i;
  assign out_valid_o = (state_q != StEmpty);
  assign in_fire     = in_valid_i && in_ready_o && !flush_i;
  assign out_fire    = out_valid_o && out_ready_i && !stall_i && !flush_i;

  // Stall needs no explicit branch: it suppresses both fires, so state holds.
  always_comb begin
    state_d  = state_q;
    main_d   = main_q;
    skid_d   = skid_q;
    drop_inc = '0;
    if (flush_i) begin
      state_d  = StEmpty;
      main_d   = BUBBLE_VAL;
      skid_d   = BUBBLE_VAL;
      drop_inc = state_q;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (in_fire) begin
            main_d  = in_data_i;
            state_d = StOne;
          end
        end
        StOne: begin
          if (in_fire && out_fire) begin
            main_d = in_data_i;
          end else if (in_fire) begin
            skid_d  = in_data_i;
            state_d = StFull;
          end else if (out_fire) begin
            main_d  = BUBBLE_VAL;
            state_d = StEmpty;
          end
        end
        StFull: begin
          if (out_fire) begin
            main_d  = skid_q;
            skid_d  = BUBBLE_VAL;
            state_d = StOne;
          end
        end
        default: begin
          state_d = StEmpty;
          main_d  = BUBBLE_VAL;
          skid_d  = BUBBLE_VAL;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StEmpty;
      main_q  <= BUBBLE_VAL;
      skid_q  <= BUBBLE_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign out_data_o  = main_q;
  assign occupancy_o = state_q;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_drop_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (drop_inc),
    .cnt_o (drop_cnt_o)
  );

endmodule

// File: tb/tb_pipe_skid_stage.sv
module tb_pipe_skid_stage;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 2;
  localparam logic [DATA_W-1:0] BUBBLE = 16'hBEEF;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [DATA_W-1:0] in_data_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [DATA_W-1:0] out_data_o;
  logic              stall_i;
  logic              flush_i;
  logic [1:0]        occupancy_o;
  logic [CNT_W-1:0]  drop_cnt_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  pipe_skid_stage #(
    .DATA_W     (DATA_W),
    .BUBBLE_VAL (BUBBLE),
    .CNT_W      (CNT_W)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .stall_i     (stall_i),
    .flush_i     (flush_i),
    .occupancy_o (occupancy_o),
    .drop_cnt_o  (drop_cnt_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i       = 1'b0;
    in_valid_i  = 1'b1;
    in_data_i   = 16'h0055;
    out_ready_i = 1'b0;
    stall_i     = 1'b0;
    flush_i     = 1'b0;

    // Reset held with valid input present
    step();
    step();
    chk("rst_out_valid", 32'(out_valid_o), 32'd0);
    chk("rst_out_data", 32'(out_data_o), 32'(BUBBLE));
    chk("rst_drop", 32'(drop_cnt_o), 32'd0);
    chk("rst_occ", 32'(occupancy_o), 32'd0);
    in_valid_i = 1'b0;
    rst_i      = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready_o), 32'd1);

    // Streaming 1..8
    out_ready_i = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid_i = 1'b1;
      in_data_i  = DATA_W'(i);
      step();
      chk("stream_data", 32'(out_data_o), 32'(i));
      chk("stream_valid", 32'(out_valid_o), 32'd1);
      chk("stream_occ", 32'(occupancy_o), 32'd1);
      chk("stream_in_ready", 32'(in_ready_o), 32'd1);
    end
    in_valid_i = 1'b0;
    step();
    chk("drain_occ", 32'(occupancy_o), 32'd0);
    chk("drain_valid", 32'(out_valid_o), 32'd0);
    chk("drain_bubble", 32'(out_data_o), 32'(BUBBLE));

    // Back-pressure
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    in_data_i   = 16'h000A;
    step();
    chk("bp_occ1", 32'(occupancy_o), 32'd1);
    chk("bp_data_a", 32'(out_data_o), 32'h000A);
    in_data_i = 16'h000B;
    step();
    chk("bp_occ2", 32'(occupancy_o), 32'd2);
    chk("bp_in_ready", 32'(in_ready_o), 32'd0);
    chk("bp_data_a_full", 32'(out_data_o), 32'h000A);
    in_data_i = 16'h000C;   // must not be accepted while FULL
    step();
    chk("bp_occ_hold", 32'(occupancy_o), 32'd2);
    chk("bp_data_hold", 32'(out_data_o), 32'h000A);
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    step();
    chk("bp_data_b", 32'(out_data_o), 32'h000B);
    chk("bp_occ_after", 32'(occupancy_o), 32'd1);
    step();
    chk("bp_empty", 32'(occupancy_o), 32'd0);
    chk("bp_bubble", 32'(out_data_o), 32'(BUBBLE));

    // Stall while FULL
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    in_data_i   = 16'h000A;
    step();
    in_data_i = 16'h000B;
    step();
    stall_i     = 1'b1;
    out_ready_i = 1'b1;
    in_data_i   = 16'h000C;
    #1;
    chk("stall_in_ready", 32'(in_ready_o), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_occ", 32'(occupancy_o), 32'd2);
      chk("stall_data", 32'(out_data_o), 32'h000A);
      chk("stall_valid", 32'(out_valid_o), 32'd1);
      chk("stall_in_ready_hold", 32'(in_ready_o), 32'd0);
    end
    stall_i    = 1'b0;
    in_valid_i = 1'b0;
    step();
    chk("unstall_data_b", 32'(out_data_o), 32'h000B);
    chk("unstall_occ", 32'(occupancy_o), 32'd1);
    step();
    chk("unstall_empty", 32'(occupancy_o), 32'd0);

    // Flush beats stall and incoming data
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    in_data_i   = 16'h000A;
    step();
    in_data_i = 16'h000B;
    step();
    chk("pre_flush_occ", 32'(occupancy_o), 32'd2);
    flush_i   = 1'b1;
    stall_i   = 1'b1;
    in_data_i = 16'h000C;
    step();
    chk("flush_occ", 32'(occupancy_o), 32'd0);
    chk("flush_valid", 32'(out_valid_o), 32'd0);
    chk("flush_bubble", 32'(out_data_o), 32'(BUBBLE));
    chk("flush_drop2", 32'(drop_cnt_o), 32'd2);
    // Flush while EMPTY with valid input: nothing stored, nothing counted
    stall_i = 1'b0;
    step();
    chk("flush_empty_occ", 32'(occupancy_o), 32'd0);
    chk("flush_empty_drop", 32'(drop_cnt_o), 32'd2);
    flush_i   = 1'b0;
    in_data_i = 16'h0011;
    step();
    chk("one_entry_occ", 32'(occupancy_o), 32'd1);
    flush_i = 1'b1;
    step();
    chk("flush_drop3", 32'(drop_cnt_o), 32'd3);
    flush_i   = 1'b0;
    in_data_i = 16'h0022;
    step();
    in_data_i = 16'h0033;
    step();
    flush_i = 1'b1;
    step();
    chk("flush_saturate", 32'(drop_cnt_o), 32'd3);
    flush_i = 1'b0;

    // Reset mid-transfer: contents lost at once, counter cleared
    in_data_i = 16'h0044;
    step();
    chk("pre_rst_occ", 32'(occupancy_o), 32'd1);
    in_valid_i = 1'b0;
    #2;
    rst_i = 1'b0;
    #1;
    chk("async_rst_occ", 32'(occupancy_o), 32'd0);
    chk("async_rst_data", 32'(out_data_o), 32'(BUBBLE));
    chk("async_rst_drop", 32'(drop_cnt_o), 32'd0);
    step();
    rst_i = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
